// File: rtl/ipf_pkg.sv
// Shared encodings for the 3x3 image filter: filter modes and scan FSM states.
package ipf_pkg;

  typedef enum logic [1:0] {
    GAUSS = 2'd0,
    LAP   = 2'd1,
    SOBEL = 2'd2,
    PASS  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ipf_linebuf.sv
// Two line buffers used as a row-parity ring: the row being written overwrites
// the row two lines back, which is read out at the same column beforehand.
module ipf_linebuf #(
  parameter int IN_W  = 8,
  parameter int IMG_W = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     sel,
  input  logic [$clog2(IMG_W)-1:0] col,
  input  logic [IN_W-1:0]          wdata,
  output logic [IN_W-1:0]          prev1,
  output logic [IN_W-1:0]          prev2
);

  logic [IN_W-1:0] mem [2][IMG_W];

  // NOTE: storage carries no reset; rows are always written before they are
  // read, and leaving the reset off lets the array map onto RAM.
  // NOTE: registered state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (we) mem[sel][col] <= wdata;
  end

  assign prev1 = mem[~sel][col];
  assign prev2 = mem[sel][col];

endmodule

// File: rtl/ipf_win3.sv
// Streaming 3x3 filter: walks the image plus one virtual row/column, so every
// centre pixel gets one zero-padded result exactly one cycle after its window is complete.
module ipf_win3
  import ipf_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int OUT_W  = 9,
  parameter int ADDR_W = 16,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [IN_W-1:0]   gray_data,
  output logic              ipf_valid,
  output logic [ADDR_W-1:0] ipf_addr,
  output logic [OUT_W-1:0]  ipf_data,
  output logic              finish
);

  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam int CW = $clog2(IMG_W);
  localparam logic [XW-1:0] X_END = XW'(IMG_W);
  localparam logic [YW-1:0] Y_END = YW'(IMG_H);
  localparam logic [YW-1:0] Y_ONE = YW'(1);
  localparam int LAP_MAX = (1 << (OUT_W - 1)) - 1;
  localparam int LAP_MIN = -(1 << (OUT_W - 1));
  localparam int SOB_MAX = (1 << OUT_W) - 1;

  state_e            state;
  mode_e             mode_q;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] pix_addr;
  logic [ADDR_W-1:0] out_addr;
  logic              walk_done;
  logic [IN_W-1:0]   win_l [3];
  logic [IN_W-1:0]   win_c [3];
  logic [IN_W-1:0]   col_n [3];
  logic [IN_W-1:0]   lb_prev1;
  logic [IN_W-1:0]   lb_prev2;
  logic              real_pos;
  logic              adv;
  logic              emit;
  logic              last_pos;
  logic [OUT_W-1:0]  result;
  int                p [3][3];
  int                gauss, lap, gx, gy, sob, res;

  assign real_pos  = (y != Y_END) && (x != X_END);
  assign gray_req  = (state == S_SCAN) && real_pos;
  assign gray_addr = pix_addr;
  assign adv       = (state == S_SCAN) && !walk_done && (!real_pos || gray_ready);
  assign emit      = (y != '0) && (x != '0);
  assign last_pos  = (y == Y_END) && (x == X_END);

  ipf_linebuf #(
    .IN_W (IN_W),
    .IMG_W(IMG_W)
  ) u_linebuf (
    .clk  (clk),
    .we   (gray_req && gray_ready),
    .sel  (y[0]),
    .col  (x[CW-1:0]),
    .wdata(gray_data),
    .prev1(lb_prev1),
    .prev2(lb_prev2)
  );

  // Incoming column: rows y-2, y-1, y at column x, zeroed outside the image.
  always_comb begin
    col_n[0] = ((y > Y_ONE) && (x != X_END)) ? lb_prev2 : '0;
    col_n[1] = ((y != '0) && (x != X_END)) ? lb_prev1 : '0;
    col_n[2] = real_pos ? gray_data : '0;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      p[r][0] = int'(win_l[r]);
      p[r][1] = int'(win_c[r]);
      p[r][2] = int'(col_n[r]);
    end
    gauss = (p[0][0] + 2 * p[0][1] + p[0][2] +
             2 * p[1][0] + 4 * p[1][1] + 2 * p[1][2] +
             p[2][0] + 2 * p[2][1] + p[2][2]) >>> 4;
    lap   = 4 * p[1][1] - p[0][1] - p[2][1] - p[1][0] - p[1][2];
    gx    = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
    gy    = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
    sob   = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
    res   = p[1][1];
    unique case (mode_q)
      GAUSS:   res = gauss;
      LAP:     res = (lap > LAP_MAX) ? LAP_MAX : ((lap < LAP_MIN) ? LAP_MIN : lap);
      SOBEL:   res = (sob > SOB_MAX) ? SOB_MAX : sob;
      default: res = p[1][1];
    endcase
  end

  assign result = OUT_W'(res);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      mode_q    <= GAUSS;
      x         <= '0;
      y         <= '0;
      pix_addr  <= '0;
      out_addr  <= '0;
      walk_done <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        win_l[r] <= '0;
        win_c[r] <= '0;
      end
      ipf_valid <= 1'b0;
      ipf_addr  <= '0;
      ipf_data  <= '0;
      finish    <= 1'b0;
    end else begin
      ipf_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (gray_ready) begin
            state     <= S_SCAN;
            mode_q    <= mode_e'(mode);
            x         <= '0;
            y         <= '0;
            pix_addr  <= '0;
            out_addr  <= '0;
            walk_done <= 1'b0;
            for (int r = 0; r < 3; r++) begin
              win_l[r] <= '0;
              win_c[r] <= '0;
            end
          end
        end
        S_SCAN: begin
          if (walk_done) begin
            // The final result was on the outputs last cycle.
            state    <= S_DONE;
            finish   <= 1'b1;
            pix_addr <= '0;
          end else if (adv) begin
            for (int r = 0; r < 3; r++) begin
              win_l[r] <= win_c[r];
              win_c[r] <= col_n[r];
            end
            if (emit) begin
              ipf_valid <= 1'b1;
              ipf_addr  <= out_addr;
              ipf_data  <= result;
              out_addr  <= out_addr + ADDR_W'(1);
            end
            if (real_pos) pix_addr <= pix_addr + ADDR_W'(1);
            if (last_pos) begin
              walk_done <= 1'b1;
            end else if (x == X_END) begin
              x <= '0;
              y <= y + YW'(1);
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        S_DONE: begin
          if (!gray_ready) begin
            state  <= S_IDLE;
            finish <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
